ifetch: RTL



---
 rtl/ifetch_pkg.sv | 13 +
 rtl/ifetch_instruction_memory.sv | 60 ++++++
 rtl/ifetch.sv | 100 ++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared instruction codes for the fetch stage: NOP/HALT words and the HALT opcode.
package ifetch_pkg;

  localparam logic [31:0] NOP_WORD    = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD   = 32'hFFFF_FFFF;
  localparam logic [5:0]  HALT_OPCODE = 6'h3F;

  // Word index addressed by a byte PC; the two low bits are ignored.
  function automatic logic [31:0] word_index(input logic [31:0] pc, input int unsigned depth);
    return (pc >> 2) % depth;
  endfunction

endpackage

// File: rtl/ifetch_instruction_memory.sv
// Debug-loadable instruction memory: append-only writes through a pointer, one-cycle clear to
// NOP, full/empty flags and asynchronous read.
module ifetch_instruction_memory
  import ifetch_pkg::*;
#(
  parameter int unsigned Depth = 64,
  parameter int unsigned Width = 32,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic [AddrW-1:0] rd_addr_i,
  output logic [Width-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wcnt_q, wcnt_d;
  logic             wr_accept;

  assign full_o    = (wcnt_q == (AddrW + 1)'(Depth));
  assign empty_o   = (wcnt_q == '0);
  assign wr_accept = wr_en_i & ~full_o & ~clear_i;
  assign rd_data_o = mem_q[rd_addr_i];

  always_comb begin
    wcnt_d = wcnt_q;
    if (clear_i) begin
      wcnt_d = '0;
    end else if (wr_accept) begin
      wcnt_d = wcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end

  // Contents survive reset; only clear or an accepted append touches the array.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (clear_i) begin
        for (int unsigned i = 0; i < Depth; i++) begin
          mem_q[i] <= Width'(NOP_WORD);
        end
      end else if (wr_accept) begin
        mem_q[wcnt_q[AddrW-1:0]] <= wr_data_i;
      end
    end
  end

endmodule

// File: rtl/ifetch.sv
// MIPS instruction-fetch stage: PC, next-PC mux, IF/ID register and optional halt detection.
// Define IFETCH_HALT_DETECT_EN to make a fetched HALT word freeze the stage until reset.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int unsigned PC_SIZE           = 32,
  parameter int unsigned BUS_SIZE          = 32,
  parameter int unsigned MEM_SIZE_IN_WORDS = 64
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_stall,
  input  logic                i_next_pc_src,
  input  logic [PC_SIZE-1:0]  i_next_not_seq_pc,
  input  logic                i_instr_wr_enable,
  input  logic [BUS_SIZE-1:0] i_instr_wr_data,
  input  logic                i_clear_mem,
  output logic [BUS_SIZE-1:0] o_instruction,
  output logic [PC_SIZE-1:0]  o_next_seq_pc,
  output logic                o_halt,
  output logic                o_mem_full,
  output logic                o_mem_empty
);

  localparam int unsigned AddrW = $clog2(MEM_SIZE_IN_WORDS);

  logic [PC_SIZE-1:0]  pc_q, pc_d, pc_plus4;
  logic [BUS_SIZE-1:0] instr_q, instr_d, fetch_word;
  logic [PC_SIZE-1:0]  seq_q, seq_d;
  logic                adv, hit_halt, halted;

  ifetch_instruction_memory #(
    .Depth(MEM_SIZE_IN_WORDS),
    .Width(BUS_SIZE)
  ) u_imem (
    .clk_i    (i_clk),
    .rst_i    (i_reset),
    .clear_i  (i_clear_mem),
    .wr_en_i  (i_instr_wr_enable),
    .wr_data_i(i_instr_wr_data),
    .rd_addr_i(pc_q[AddrW+1:2]),
    .rd_data_o(fetch_word),
    .full_o   (o_mem_full),
    .empty_o  (o_mem_empty)
  );

  assign pc_plus4 = pc_q + PC_SIZE'(4);
  assign adv      = i_enable & ~i_stall & ~halted;

`ifdef IFETCH_HALT_DETECT_EN
  logic halted_q;

  assign hit_halt = (fetch_word == BUS_SIZE'(HALT_WORD));
  assign halted   = halted_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      halted_q <= 1'b0;
    end else if (adv && hit_halt) begin
      halted_q <= 1'b1;
    end
  end
`else
  assign hit_halt = 1'b0;
  assign halted   = 1'b0;
`endif

  assign o_halt = halted;

  // A redirect only steers the PC; the word already fetched is latched as the delay slot.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    seq_d   = seq_q;
    if (adv) begin
      instr_d = fetch_word;
      seq_d   = pc_plus4;
      if (!hit_halt) begin
        pc_d = i_next_pc_src ? i_next_not_seq_pc : pc_plus4;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_q    <= '0;
      instr_q <= BUS_SIZE'(NOP_WORD);
      seq_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      seq_q   <= seq_d;
    end
  end

  assign o_instruction = instr_q;
  assign o_next_seq_pc = seq_q;

endmodule
